stream_mux_rr: RTL and testbench
================================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the bit width of each data channel (legal range 1..64).
REQ-002 The block SHALL have parameter N, default 4, meaning the number of input channels (legal range 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port s_data, input, N*WIDTH bits: channel i data occupies bits [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have port s_valid, input, N bits: bit i high means channel i offers a word.
REQ-007 The block SHALL have port s_ready, output, N bits: bit i high means channel i's word is accepted this cycle.
REQ-008 The block SHALL have port m_data, output, WIDTH bits: registered selected word.
REQ-009 The block SHALL have port m_valid, output, 1 bit: m_data holds a word not yet consumed.
REQ-010 The block SHALL have port m_ready, input, 1 bit: downstream accepts m_data this cycle.
REQ-011 The block SHALL have port m_sel, output, $clog2(N) bits: index of the channel that supplied m_data.

Function
REQ-012 A transfer on channel i SHALL occur when s_valid[i] and s_ready[i] are both high at a rising clk edge; an output transfer SHALL occur when m_valid and m_ready are both high.
REQ-013 The load condition SHALL be load_en = !m_valid || m_ready (output register empty, or being drained this cycle).
REQ-014 The grant SHALL be computed combinationally among channels with s_valid high, using the arbitration rule in REQ-028/REQ-029.
REQ-015 s_ready[i] SHALL be high only when load_en is high, i is the granted channel, and s_valid[i] is high; at most one s_ready bit SHALL be high in any cycle.
REQ-016 s_ready SHALL be all zero when no s_valid bit is high.
REQ-017 On an input transfer from channel g, the next edge SHALL load m_data with channel g's word, set m_sel to g, and set m_valid to 1; latency from input transfer to m_valid is 1 cycle.
REQ-018 An output transfer with no simultaneous input transfer SHALL clear m_valid at the next edge; m_data and m_sel SHALL hold their values.
REQ-019 When an output transfer and an input transfer occur in the same cycle, the new word SHALL replace the old one with m_valid staying 1, so sustained throughput is 1 word/cycle.
REQ-020 While m_valid is high and m_ready is low, m_data and m_sel SHALL be stable and all s_ready bits SHALL be 0.
REQ-021 A source SHALL hold its s_valid and s_data until accepted; the block SHALL NOT drop or duplicate words.
REQ-022 There SHALL be no combinational path from m_ready to m_data or m_valid.

Reset
REQ-023 While rst is high, m_valid SHALL be 0, m_data SHALL be 0, m_sel SHALL be 0, and the round-robin pointer SHALL be 0, all asynchronously.
REQ-024 While rst is high, s_ready SHALL be all zero.
REQ-025 A word held in the output register when rst asserts SHALL be discarded.
REQ-026 The first edge after rst deasserts SHALL be able to perform an input transfer.

Configuration
REQ-027 The macro STREAM_MUX_RR_EN SHALL select the arbitration rule at compile time.
REQ-028 With STREAM_MUX_RR_EN defined, arbitration SHALL be round-robin:
- the search starts at pointer p and proceeds p, p+1, ..., wrapping modulo N;
- the first valid channel wins;
- after an input transfer from channel g, p SHALL become (g+1) mod N, with wrap from N-1 to 0;
- p SHALL be unchanged in cycles with no input transfer.
REQ-029 Without STREAM_MUX_RR_EN, arbitration SHALL be fixed priority: the lowest-index valid channel wins, and no pointer state is implemented.

Verification
REQ-030 The bench SHALL run these directed scenarios with WIDTH=8, N=4:
- Reset: rst=1 with arbitrary inputs -> m_valid=0, m_data=0x00, m_sel=0, s_ready=0000.
- Single channel: s_valid=0010, ch1 data=0x10, m_ready=1 -> s_ready=0010 in that cycle; next cycle m_data=0x10, m_sel=1, m_valid=1.
- Backpressure: m_ready=0 with m_valid=1 for 5 cycles -> m_data and m_sel stable, s_ready=0000; release m_ready -> pending word accepted on the same edge the old word drains.
- Round robin (macro defined): all four channels valid continuously, m_ready=1 -> m_sel sequence 0,1,2,3,0,1, one word per cycle.
- Fixed priority (macro undefined): same stimulus -> m_sel stays 0 while ch0 is valid; drop ch0 -> m_sel=1.
- Wrap and reset mid-stream: grant ch3 (pointer wraps to 0), assert rst with m_valid=1 -> word lost, pointer=0; next grant with s_valid=1111 goes to ch0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N-input to 1-output stream multiplexer with a registered output stage.
//   A grant is chosen every cycle among channels whose s_valid is high.
//   The granted word is accepted whenever the output register is empty or
//   is being drained in the same cycle, which gives one word per cycle.
//
//   Compile-time option:
//     STREAM_MUX_RR_EN  defined   -> round-robin arbitration with a pointer
//                       undefined -> fixed priority, lowest index wins
//
//   Handshake: a word moves on any interface when its valid and ready are
//   both high at a rising clk edge; a source holds its valid and data until
//   that edge. s_ready depends on s_valid and m_ready. m_data, m_valid and
//   m_sel come straight from registers.
//
// Ports
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   s_data   N*WIDTH input words, channel i at [i*WIDTH +: WIDTH]
//   s_valid  per-channel offer
//   s_ready  per-channel accept, at most one bit set
//   m_data   registered selected word
//   m_valid  m_data holds an unconsumed word
//   m_ready  downstream accepts m_data
//   m_sel    channel index that supplied m_data
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*WIDTH-1:0]     s_data,
  input  logic [N-1:0]           s_valid,
  output logic [N-1:0]           s_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(N)-1:0]   m_sel
);

  localparam int SW = $clog2(N);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SW-1:0]    r_sel;

  logic             w_load_en;
  logic             w_any;
  logic             w_xfer;
  logic [SW-1:0]    w_grant;
  logic [WIDTH-1:0] w_grant_data;

  // Output register can take a word when empty or when draining this cycle.
  assign w_load_en    = !r_valid || m_ready;
  assign w_any        = |s_valid;
  assign w_xfer       = w_load_en && w_any;
  assign w_grant_data = s_data[int'(w_grant)*WIDTH +: WIDTH];

`ifdef STREAM_MUX_RR_EN
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] w_idx;
  logic          w_found;

  // Search starts at the pointer and wraps modulo N; first valid wins.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = SW'((int'(r_ptr) + k) % N);
      if (!w_found && s_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Pointer moves just past the winner, only on an accepted input word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_grant == SW'(N - 1)) ? '0 : w_grant + SW'(1);
    end
  end
`else
  // Fixed priority: scanning downwards leaves the lowest valid index.
  always_comb begin
    w_grant = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (s_valid[i]) w_grant = SW'(i);
    end
  end
`endif

  // One-hot accept; forced low while reset is asserted.
  always_comb begin
    s_ready = '0;
    if (!rst && w_xfer) s_ready[w_grant] = 1'b1;
  end

  // Output stage: load on accept, clear valid on drain without refill,
  // otherwise hold (covers backpressure).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= '0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_data  <= w_grant_data;
        r_sel   <= w_grant;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign m_data  = r_data;
  assign m_valid = r_valid;
  assign m_sel   = r_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [N*WIDTH-1:0] s_data;
  logic [N-1:0]     s_valid;
  logic [N-1:0]     s_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [1:0]       m_sel;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sel   (m_sel)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [WIDTH-1:0] val);
    s_data[ch*WIDTH +: WIDTH] = val;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                         input logic [1:0] s);
    chk({tag, ".m_valid"}, m_valid, v);
    chk({tag, ".m_data"},  m_data,  d);
    chk({tag, ".m_sel"},   m_sel,   s);
  endtask

  logic [1:0] exp_sel;
  logic [3:0] exp_rdy;

  initial begin
    // ---------------- reset with arbitrary inputs ----------------
    rst     = 1'b1;
    s_valid = 4'b1111;
    s_data  = 32'hDEADBEEF;
    m_ready = 1'b1;
    #1;
    chk("rst.s_ready", s_ready, 4'b0000);
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    tick();
    chk("rst_edge.s_ready", s_ready, 4'b0000);
    chk_out("rst_edge", 1'b0, 8'h00, 2'd0);

    // ---------------- single channel ----------------
    s_valid = 4'b0010;
    s_data  = '0;
    set_ch(1, 8'h10);
    m_ready = 1'b1;
    rst     = 1'b0;
    #1;
    chk("single.s_ready", s_ready, 4'b0010);
    tick();
    chk_out("single", 1'b1, 8'h10, 2'd1);
    s_valid = 4'b0000;
    #1;
    chk("idle.s_ready", s_ready, 4'b0000);
    tick();
    // Drained with no refill: valid drops, data and sel hold.
    chk_out("drain", 1'b0, 8'h10, 2'd1);

    // ---------------- backpressure ----------------
    s_valid = 4'b0100;
    set_ch(2, 8'h22);
    tick();
    chk_out("bp_load", 1'b1, 8'h22, 2'd2);
    m_ready = 1'b0;
    s_valid = 4'b0001;
    set_ch(0, 8'h0A);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp.s_ready", s_ready, 4'b0000);
      tick();
      chk_out("bp_hold", 1'b1, 8'h22, 2'd2);
    end
    m_ready = 1'b1;
    #1;
    chk("bp_rel.s_ready", s_ready, 4'b0001);
    tick();
    chk_out("bp_rel", 1'b1, 8'h0A, 2'd0);
    s_valid = 4'b0000;
    tick();
    chk("bp_empty.m_valid", m_valid, 1'b0);

    // Reset pulse so arbitration starts from pointer 0.
    rst = 1'b1;
    #1;
    chk_out("rst_mid", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;

    // ---------------- all channels valid ----------------
    for (int i = 0; i < N; i++) set_ch(i, 8'hA0 + 8'(i));
    s_valid = 4'b1111;
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
`ifdef STREAM_MUX_RR_EN
      exp_sel = 2'(c % 4);
`else
      exp_sel = 2'd0;
`endif
      exp_rdy = 4'b0001 << exp_sel;
      #1;
      chk("all.s_ready", s_ready, exp_rdy);
      tick();
      chk_out("all", 1'b1, 8'hA0 + 8'(exp_sel), exp_sel);
    end
    // Drop ch0: fixed priority moves to ch1; round robin pointer is at 2.
    s_valid = 4'b1110;
`ifdef STREAM_MUX_RR_EN
    exp_sel = 2'd2;
`else
    exp_sel = 2'd1;
`endif
    tick();
    chk_out("drop0", 1'b1, 8'hA0 + 8'(exp_sel), exp_sel);

    // ---------------- wrap and reset mid-stream ----------------
    s_valid = 4'b1000;
    set_ch(3, 8'h33);
    tick();
    chk_out("wrap", 1'b1, 8'h33, 2'd3);
    s_valid = 4'b0000;
    m_ready = 1'b0;
    tick();
    chk_out("wrap_hold", 1'b1, 8'h33, 2'd3);
    rst = 1'b1;
    #1;
    chk("wrap_rst.s_ready", s_ready, 4'b0000);
    chk_out("wrap_rst", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    s_valid = 4'b1111;
    m_ready = 1'b1;
    #1;
    chk("post_rst.s_ready", s_ready, 4'b0001);
    tick();
    chk_out("post_rst", 1'b1, 8'hA0, 2'd0);

    // Reset must also clear a non-zero pointer: grant ch1 (pointer -> 2),
    // hold it, reset, then all-valid must go to ch0 again.
    s_valid = 4'b0010;
    tick();
    chk_out("ptr_ch1", 1'b1, 8'hA1, 2'd1);
    s_valid = 4'b0000;
    m_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk_out("ptr_rst", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    s_valid = 4'b1111;
    m_ready = 1'b1;
    #1;
    chk("ptr_post.s_ready", s_ready, 4'b0001);
    tick();
    chk_out("ptr_post", 1'b1, 8'hA0, 2'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
